queue: RTL and testbench

Eight-entry byte FIFO that sits directly downstream of the serial-to-byte deserializer stage. It accepts each completed byte through the deserializer's ready/acknowledge handshake (`data_ready` → `enqueue_in`, `ack_out` → `ack_in`). Bytes are presented first-word-fall-through to the consumer, which pops them with a one-cycle `dequeue_in` strobe. When the queue is full, the acknowledge is withheld, which stalls the deserializer in its ready state.

---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_mem.sv | 36 +++
 rtl/queue.sv | 115 +++++++++++
 tb/tb_queue.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared types and default sizes for the byte queue.
//   enq_state_t : enqueue handshake FSM states
//   QUEUE_DEPTH : default number of entries
//   QUEUE_WIDTH : default entry width in bits
package queue_pkg;

    localparam int unsigned QUEUE_DEPTH = 8;
    localparam int unsigned QUEUE_WIDTH = 8;

    typedef enum logic [1:0] {
        WAIT,
        ACK,
        HOLD
    } enq_state_t;

endpackage

// File: rtl/queue_mem.sv
// Register-array storage for the queue: synchronous write, asynchronous read.
// Contents are not reset; validity is tracked by the owner.
//   clock_100  : write clock
//   write_en   : store write_data at write_addr on the rising edge
//   write_addr : write index
//   write_data : entry to store
//   read_addr  : read index
//   read_data  : entry at read_addr (combinational)
module queue_mem
    import queue_pkg::*;
#(
    parameter  int unsigned DEPTH  = QUEUE_DEPTH,
    parameter  int unsigned WIDTH  = QUEUE_WIDTH,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock_100,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [WIDTH-1:0]  write_data,
    input  logic [ADDR_W-1:0] read_addr,
    output logic [WIDTH-1:0]  read_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock_100) begin
        if (write_en) begin
            mem[write_addr] <= write_data;
        end
    end

    // Read port.
    assign read_data = mem[read_addr];

endmodule

// File: rtl/queue.sv
// Byte FIFO fed by the deserializer's ready/ack handshake, first-word-fall-through
// to the consumer.
//   clock_100  : system clock
//   reset      : asynchronous active-low reset
//   data_in    : byte offered upstream
//   enqueue_in : upstream byte valid, held until acknowledged
//   ack_out    : one-cycle acknowledge that data_in was stored
//   dequeue_in : consumer pop strobe
//   data_out   : head entry, 0 when empty
//   len_out    : number of stored entries
//   empty      : len_out == 0
//   full       : len_out == DEPTH
module queue
    import queue_pkg::*;
#(
    parameter  int unsigned DEPTH = QUEUE_DEPTH,
    parameter  int unsigned WIDTH = QUEUE_WIDTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LEN_W = PTR_W + 1
) (
    input  logic             clock_100,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enqueue_in,
    output logic             ack_out,
    input  logic             dequeue_in,
    output logic [WIDTH-1:0] data_out,
    output logic [LEN_W-1:0] len_out,
    output logic             empty,
    output logic             full
);

    enq_state_t       state;
    enq_state_t       state_nxt;
    logic             ack_nxt;
    logic             wr_en;
    logic             rd_en;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LEN_W-1:0] len_nxt;
    logic [WIDTH-1:0] head;

    queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clock_100  (clock_100),
        .write_en   (wr_en),
        .write_addr (wr_ptr),
        .write_data (data_in),
        .read_addr  (rd_ptr),
        .read_data  (head)
    );

    // Enqueue handshake: write only from WAIT, so a byte still held high while
    // upstream reacts to the ack is never stored twice.
    always_comb begin
        state_nxt = state;
        ack_nxt   = 1'b0;
        wr_en     = 1'b0;
        case (state)
            WAIT: begin
                if (enqueue_in && !full) begin
                    wr_en     = 1'b1;
                    ack_nxt   = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = enqueue_in ? HOLD : WAIT;
            HOLD:    state_nxt = enqueue_in ? HOLD : WAIT;
            default: state_nxt = WAIT;
        endcase
    end

    // Pops while empty are ignored.
    assign rd_en = dequeue_in && !empty;

    // Occupancy counter, independent of the pointers.
    always_comb begin
        len_nxt = len_out;
        case ({wr_en, rd_en})
            2'b10:   len_nxt = len_out + LEN_W'(1);
            2'b01:   len_nxt = len_out - LEN_W'(1);
            default: len_nxt = len_out;
        endcase
    end

    // State, pointers and flags; flags are registered from the next length.
    always_ff @(posedge clock_100 or negedge reset) begin
        if (!reset) begin
            state   <= WAIT;
            ack_out <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            len_out <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ack_out <= ack_nxt;
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            len_out <= len_nxt;
            empty   <= (len_nxt == '0);
            full    <= (len_nxt == LEN_W'(DEPTH));
        end
    end

    assign data_out = empty ? '0 : head;

endmodule

// File: tb/tb_queue.sv
// Self-checking bench for queue: expected bytes are queued as stimulus is issued;
// a monitor compares data_out against them on every accepted pop.
module tb_queue;

    logic       clock_100;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       ack_out;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic [3:0] len_out;
    logic       empty;
    logic       full;

    int         n_cmp   = 0;
    int         n_err   = 0;
    int         ack_cnt = 0;
    logic [7:0] exp_q[$];

    queue dut (
        .clock_100  (clock_100),
        .reset      (reset),
        .data_in    (data_in),
        .enqueue_in (enqueue_in),
        .ack_out    (ack_out),
        .dequeue_in (dequeue_in),
        .data_out   (data_out),
        .len_out    (len_out),
        .empty      (empty),
        .full       (full)
    );

    initial clock_100 = 1'b0;
    always #5 clock_100 = ~clock_100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs just after the active edge.
    task automatic tick();
        @(posedge clock_100);
        #1;
    endtask

    // Full upstream handshake: hold until ack, drop after the next edge.
    task automatic enqueue(input logic [7:0] b);
        logic got;
        got = 1'b0;
        exp_q.push_back(b);
        data_in    = b;
        enqueue_in = 1'b1;
        for (int i = 0; i < 16 && !got; i++) begin
            tick();
            got = ack_out;
        end
        check("enq_ack", 32'(got), 32'd1);
        tick();
        enqueue_in = 1'b0;
        tick();
    endtask

    task automatic pop();
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  32'(data_out), 32'd0);
        check({tag, "_empty"}, 32'(empty),    32'd1);
        check({tag, "_len"},   32'(len_out),  32'd0);
        check({tag, "_ack"},   32'(ack_out),  32'd0);
        check({tag, "_full"},  32'(full),     32'd0);
    endtask

    // Pop monitor: head byte must match the oldest expected byte.
    always @(negedge clock_100) begin
        if (reset && dequeue_in && !empty) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_data: got %0h expected no entry", data_out);
            end else begin
                check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    always @(negedge clock_100) begin
        if (ack_out) ack_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a0;
        reset      = 1'b1;
        data_in    = 8'h00;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("rst");
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("rel");

        // Handshake held for three cycles yields one entry, one ack.
        exp_q.push_back(8'hA5);
        a0         = ack_cnt;
        data_in    = 8'hA5;
        enqueue_in = 1'b1;
        tick();
        tick();
        tick();
        check("hs_len",  32'(len_out),  32'd1);
        check("hs_data", 32'(data_out), 32'hA5);
        enqueue_in = 1'b0;
        tick();
        tick();
        check("hs_acks", 32'(ack_cnt - a0), 32'd1);
        check("hs_len2", 32'(len_out),      32'd1);
        pop();
        check("hs_empty", 32'(empty), 32'd1);

        // Fill, then stall on the ninth byte until a pop frees a slot.
        for (int i = 1; i <= 8; i++) enqueue(8'(i));
        check("fill_full", 32'(full),    32'd1);
        check("fill_len",  32'(len_out), 32'd8);
        exp_q.push_back(8'h09);
        a0         = ack_cnt;
        data_in    = 8'h09;
        enqueue_in = 1'b1;
        repeat (4) tick();
        check("stall_noack", 32'(ack_cnt - a0), 32'd0);
        check("stall_len",   32'(len_out),      32'd8);
        pop();
        check("stall_head",  32'(data_out), 32'h02);
        check("stall_ack0",  32'(ack_out),  32'd0);
        check("stall_len7",  32'(len_out),  32'd7);
        tick();
        check("stall_ack1",  32'(ack_out),  32'd1);
        check("stall_len8",  32'(len_out),  32'd8);
        tick();
        enqueue_in = 1'b0;
        tick();

        // Drain across the pointer wrap.
        repeat (8) pop();
        check("drain_empty", 32'(empty),    32'd1);
        check("drain_data",  32'(data_out), 32'd0);
        check("drain_len",   32'(len_out),  32'd0);
        pop();
        check("extra_len",   32'(len_out),  32'd0);
        check("extra_empty", 32'(empty),    32'd1);

        // Simultaneous write and pop keeps the length.
        enqueue(8'h11);
        enqueue(8'h22);
        enqueue(8'h33);
        check("sim_len0", 32'(len_out), 32'd3);
        exp_q.push_back(8'h3C);
        data_in    = 8'h3C;
        enqueue_in = 1'b1;
        dequeue_in = 1'b1;
        tick();
        dequeue_in = 1'b0;
        check("sim_len",  32'(len_out),  32'd3);
        check("sim_ack",  32'(ack_out),  32'd1);
        check("sim_head", 32'(data_out), 32'h22);
        tick();
        enqueue_in = 1'b0;
        tick();
        repeat (3) pop();
        check("sim_empty", 32'(empty), 32'd1);

        // Reset while in ACK with five entries.
        for (int i = 0; i < 4; i++) enqueue(8'h50 + 8'(i));
        data_in    = 8'h55;
        enqueue_in = 1'b1;
        tick();
        check("mid_len5", 32'(len_out), 32'd5);
        check("mid_ack",  32'(ack_out), 32'd1);
        #2 reset = 1'b0;
        exp_q.delete();
        #1 check_reset_outputs("mid");
        @(posedge clock_100);
        #1 reset = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        check("post_ack",  32'(ack_out),  32'd1);
        check("post_len",  32'(len_out),  32'd1);
        check("post_data", 32'(data_out), 32'h55);
        tick();
        enqueue_in = 1'b0;
        tick();
        pop();
        check("post_empty", 32'(empty),        32'd1);
        check("exp_left",   32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
